// File: rtl/tap_sum_sched_if.sv
// Bundle of the requester, flush and result signals between the tap-sum
// scheduler and its surroundings. The scheduler sits on the slave side.
interface tap_sum_sched_if #(
   parameter int NCH = 4,
   parameter int DW  = 8,
   parameter int SW  = 12
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0]    req_valid;
   logic [NCH*DW-1:0] req_data;
   logic [NCH-1:0]    req_ready;
   logic [NCH-1:0]    flush;
   logic              out_valid;
   logic [CW-1:0]     out_chan;
   logic [SW-1:0]     out_sum;
   logic              out_ready;
   logic              busy;

   modport master (
      output req_valid, req_data, flush, out_ready,
      input  req_ready, out_valid, out_chan, out_sum, busy
   );

   modport slave (
      input  req_valid, req_data, flush, out_ready,
      output req_ready, out_valid, out_chan, out_sum, busy
   );
endinterface

// File: rtl/tap_sum_sched.sv
// Shared moving-sum engine: NCH channels each keep an NTAPS-deep sample
// history; one channel at a time is granted round-robin, its history is
// summed one tap per cycle, and the result is held until the consumer takes it.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting; grants first eligible channel at/after ptr
// ACC   | adding hist[gch][k], k = 0 .. NTAPS-1, one tap per cycle
// OUT   | result presented on out_*, held until out_ready
module tap_sum_sched #(
   parameter int NCH   = 4,
   parameter int NTAPS = 5,
   parameter int DW    = 8,
   parameter int SW    = 12
) (
   input logic            clk,
   input logic            reset,
   tap_sum_sched_if.slave bus
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int KW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NTAPS - 1);

   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

   state_t            state, state_nxt;
   logic [DW-1:0]     hist [NCH][NTAPS];
   logic [CW-1:0]     ptr;
   logic [CW-1:0]     gch;
   logic [KW-1:0]     k;
   logic [SW-1:0]     acc;
   logic [SW-1:0]     acc_sum;
   logic              out_valid_q;
   logic [SW-1:0]     out_sum_q;
   logic [CW-1:0]     out_chan_q;
   logic              grant_found;
   logic [CW-1:0]     grant_idx;
   logic [CW:0]       scan_wide;
   logic [CW-1:0]     scan_idx;
   logic [NCH-1:0]    req_ready_c;
   logic              handshake;

   // Round-robin search: scan backwards so the last hit is the one closest to ptr.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_wide   = '0;
      scan_idx    = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         scan_wide = {1'b0, ptr} + (CW+1)'(i);
         if (scan_wide >= (CW+1)'(NCH)) scan_wide = scan_wide - (CW+1)'(NCH);
         scan_idx = scan_wide[CW-1:0];
         if (bus.req_valid[scan_idx] && !bus.flush[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // Accept strobe: only in IDLE, only for the granted channel, never under reset.
   always_comb begin
      req_ready_c = '0;
      if (state == IDLE && !reset && grant_found) req_ready_c[grant_idx] = 1'b1;
   end

   assign handshake     = (state == IDLE) && grant_found;
   assign acc_sum       = acc + {{(SW-DW){1'b0}}, hist[gch][k]};
   assign bus.req_ready = req_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_chan  = out_chan_q;
   assign bus.busy      = (state != IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_found) state_nxt = ACC;
         ACC:     if (k == K_LAST) state_nxt = OUT;
         OUT:     if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Histories, accumulator, tap index, pointer and registered result.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NCH; c++)
            for (int t = 0; t < NTAPS; t++)
               hist[c][t] <= '0;
         ptr         <= '0;
         gch         <= '0;
         k           <= '0;
         acc         <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_chan_q  <= '0;
      end else begin
         // A flushed channel is never granted, so flush and shift never collide.
         for (int c = 0; c < NCH; c++) begin
            if (bus.flush[c]) begin
               for (int t = 0; t < NTAPS; t++) hist[c][t] <= '0;
            end else if (handshake && grant_idx == CW'(c)) begin
               for (int t = NTAPS - 1; t > 0; t--) hist[c][t] <= hist[c][t-1];
               hist[c][0] <= bus.req_data[c*DW +: DW];
            end
         end
         case (state)
            IDLE: begin
               if (grant_found) begin
                  gch <= grant_idx;
                  acc <= '0;
                  k   <= '0;
               end
            end
            ACC: begin
               acc <= acc_sum;
               k   <= k + 1'b1;
               if (k == K_LAST) begin
                  out_valid_q <= 1'b1;
                  out_sum_q   <= acc_sum;
                  out_chan_q  <= gch;
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  ptr         <= (gch == CW'(NCH - 1)) ? '0 : gch + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_tap_sum_sched.sv
// Bench for tap_sum_sched: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a transaction-level model.
module tb_tap_sum_sched;
   localparam int NCH   = 4;
   localparam int NTAPS = 5;
   localparam int DW    = 8;
   localparam int SW    = 12;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   tap_sum_sched_if #(.NCH(NCH), .DW(DW), .SW(SW)) bus ();
   tap_sum_sched #(.NCH(NCH), .NTAPS(NTAPS), .DW(DW), .SW(SW)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: per-channel histories as plain integers; an operation is a
   // snapshot of the history taken at accept, whose not-yet-read taps drop
   // to zero if that channel is flushed while the taps are being read.
   int m_hist [NCH][NTAPS];
   int snap   [NTAPS];
   int mode = 0;              // 0 idle, 1 summing, 2 result presented
   int m_ptr = 0;
   int exp_sum = 0, exp_ch = 0, t_acc = 0, cyc = 0, last_acc = 0;
   bit prev_ov = 1'b0;
   int res_sum[$], res_ch[$], lat_q[$], grant_q[$];

   initial begin
      for (int c = 0; c < NCH; c++)
         for (int t = 0; t < NTAPS; t++) m_hist[c][t] = 0;
   end

   always @(negedge clk) begin
      int g;
      int kk;
      int dg;
      logic [NCH-1:0] er;
      cyc++;
      g  = -1;
      dg = -1;
      er = '0;
      if (!reset && mode == 0)
         for (int i = 0; i < NCH; i++) begin
            int c;
            c = (m_ptr + i) % NCH;
            if (g < 0 && bus.req_valid[c] && !bus.flush[c]) g = c;
         end
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", bus.req_ready, er);
      chk("busy", bus.busy, mode != 0);
      chk("out_valid", bus.out_valid, mode == 2);
      if (mode == 2) begin
         chk("out_sum", bus.out_sum, exp_sum);
         chk("out_chan", bus.out_chan, exp_ch);
      end
      if (bus.out_valid && !prev_ov) lat_q.push_back(cyc - last_acc);
      prev_ov = bus.out_valid;
      if (bus.out_valid && bus.out_ready && !reset) begin
         res_sum.push_back(int'(bus.out_sum));
         res_ch.push_back(int'(bus.out_chan));
      end
      for (int c = 0; c < NCH; c++) if (bus.req_ready[c]) dg = c;
      if (dg >= 0) begin
         grant_q.push_back(dg);
         last_acc = cyc;
      end
      if (reset) begin
         for (int c = 0; c < NCH; c++)
            for (int t = 0; t < NTAPS; t++) m_hist[c][t] = 0;
         mode  = 0;
         m_ptr = 0;
      end else begin
         case (mode)
            0: if (g >= 0) begin
               for (int t = NTAPS - 1; t > 0; t--) m_hist[g][t] = m_hist[g][t-1];
               m_hist[g][0] = int'(bus.req_data[g*DW +: DW]);
               exp_sum = 0;
               for (int t = 0; t < NTAPS; t++) begin
                  snap[t] = m_hist[g][t];
                  exp_sum += snap[t];
               end
               exp_ch = g;
               t_acc  = cyc;
               mode   = 1;
            end
            1: begin
               kk = cyc - t_acc - 1;
               if (bus.flush[exp_ch])
                  for (int j = kk + 1; j < NTAPS; j++) begin
                     exp_sum -= snap[j];
                     snap[j] = 0;
                  end
               if (kk == NTAPS - 1) mode = 2;
            end
            default: if (bus.out_ready) begin
               mode  = 0;
               m_ptr = (exp_ch + 1) % NCH;
            end
         endcase
         for (int c = 0; c < NCH; c++)
            if (bus.flush[c])
               for (int t = 0; t < NTAPS; t++) m_hist[c][t] = 0;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   task automatic send(input int c, input int v);
      bit ok;
      ok = 1'b0;
      bus.req_valid[c] = 1'b1;
      bus.req_data[c*DW +: DW] = v[DW-1:0];
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         if (bus.req_ready[c]) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.req_valid[c] = 1'b0;
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_results(input int n);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (res_sum.size() >= n) begin
            ok = 1'b1;
            break;
         end
         step(1);
      end
      if (!ok) chk("result_timeout", res_sum.size(), n);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, lb, gb, gq;
      int e33 [6];
      bit seen;
      e33 = '{10, 30, 60, 100, 150, 200};
      reset         = 1'b1;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.flush     = '0;
      bus.out_ready = 1'b1;
      step(3);
      reset = 1'b0;
      chk("rst_busy", bus.busy, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_sum", bus.out_sum, 0);
      chk("rst_out_chan", bus.out_chan, 0);
      chk("rst_req_ready", bus.req_ready, 0);

      // single channel moving sum
      base = res_sum.size();
      lb   = lat_q.size();
      for (int i = 0; i < 6; i++) send(0, e33[i] - ((i == 0) ? 0 : e33[i-1]) + ((i >= 5) ? 10 : 0));
      wait_results(base + 6);
      for (int i = 0; i < 6; i++) begin
         chk("single_sum", res_sum[base+i], e33[i]);
         chk("single_chan", res_ch[base+i], 0);
         chk("single_latency", lat_q[lb+i], NTAPS + 1);
      end

      // round robin
      do_reset();
      base = res_sum.size();
      gb   = grant_q.size();
      for (int c = 0; c < NCH; c++) bus.req_data[c*DW +: DW] = DW'(c + 1);
      bus.req_valid = '1;
      wait_results(base + 8);
      bus.req_valid = '0;
      step(2);
      for (int i = 0; i < 5; i++) chk("rr_grant", grant_q[gb+i], i % 4);
      for (int c = 0; c < NCH; c++) begin
         chk("rr_sum_round2", res_sum[base+4+c], 2 * (c + 1));
         chk("rr_chan_round2", res_ch[base+4+c], c);
      end

      // backpressure
      bus.out_ready = 1'b0;
      send(3, 5);
      bus.req_valid[1] = 1'b1;
      bus.req_data[1*DW +: DW] = 8'd6;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid) begin
            seen = 1'b1;
            break;
         end
         step(1);
      end
      chk("bp_out_valid_seen", seen, 1);
      gq = grant_q.size();
      step(10);
      chk("bp_no_accept", grant_q.size(), gq);
      chk("bp_valid_held", bus.out_valid, 1);
      chk("bp_sum_held", bus.out_sum, 13);
      chk("bp_chan_held", bus.out_chan, 3);
      base = res_sum.size();
      bus.out_ready = 1'b1;
      send(1, 6);
      wait_results(base + 2);
      chk("bp_sum_ch3", res_sum[base], 13);
      chk("bp_sum_ch1", res_sum[base+1], 10);
      chk("bp_chan_ch1", res_ch[base+1], 1);

      // max value
      do_reset();
      base = res_sum.size();
      for (int i = 0; i < 5; i++) send(2, 255);
      wait_results(base + 5);
      chk("max_sum", res_sum[base+4], 1275);
      chk("max_chan", res_ch[base+4], 2);

      // flush
      do_reset();
      base = res_sum.size();
      for (int i = 0; i < 4; i++) send(1, 100);
      wait_results(base + 4);
      chk("flush_pre_sum", res_sum[base+3], 400);
      bus.flush[1] = 1'b1;
      step(1);
      bus.flush[1] = 1'b0;
      send(1, 7);
      wait_results(base + 5);
      chk("flush_post_sum", res_sum[base+4], 7);
      bus.flush[1]     = 1'b1;
      bus.req_valid[1] = 1'b1;
      @(negedge clk);
      chk("flush_blocks_ready", bus.req_ready[1], 0);
      @(posedge clk);
      #1;
      bus.flush[1]     = 1'b0;
      bus.req_valid[1] = 1'b0;
      step(2);

      // reset in the third summing cycle
      do_reset();
      send(0, 50);
      step(2);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      base = res_sum.size();
      lb   = lat_q.size();
      step(15);
      chk("rstacc_no_result", res_sum.size(), base);
      chk("rstacc_no_valid", lat_q.size(), lb);
      chk("rstacc_busy", bus.busy, 0);
      chk("rstacc_out_sum", bus.out_sum, 0);
      chk("rstacc_out_chan", bus.out_chan, 0);
      send(0, 9);
      wait_results(base + 1);
      chk("rstacc_after_sum", res_sum[base], 9);

      // randomized traffic
      do_reset();
      base = res_sum.size();
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < NCH; c++) begin
            bus.req_valid[c] = ($urandom_range(0, 2) != 0);
            bus.flush[c]     = ($urandom_range(0, 19) == 0);
         end
         bus.req_data  = {$urandom, $urandom};
         bus.out_ready = ($urandom_range(0, 9) < 7);
         reset         = ($urandom_range(0, 499) == 0);
         step(1);
      end
      bus.req_valid = '0;
      bus.flush     = '0;
      bus.out_ready = 1'b1;
      reset         = 1'b0;
      step(20);
      chk("random_activity", res_sum.size() - base > 50, 1);
      chk("random_idle_at_end", bus.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
